// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Two-requester round-robin arbiter and sequencer for a single-port
//   register memory (reg_mem).  It owns the memory's addr/data_in/wen port
//   and serialises read and write transactions from two requesters that use
//   a req/ack handshake.  Each transaction goes IDLE -> ACCESS -> ACK, so one
//   transaction completes every three cycles.  All outputs are registered.
//
//   Optional build macro: ARB_STATS_EN adds saturating 16-bit grant counters.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   rN_req/we/addr/wdata      requester N transaction (held until rN_ack)
//   rN_ack                    one-cycle completion pulse
//   rN_rdata                  read result, valid with ack, held afterwards
//   mem_addr/mem_din/mem_wen  memory port (to reg_mem)
//   mem_dout                  memory combinational read data
//   rN_grant_cnt              (ARB_STATS_EN only) grants given to requester N
module mem_port_arbiter #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_BITS  = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  r0_req,
   input  logic                  r0_we,
   input  logic [ADDR_BITS-1:0]  r0_addr,
   input  logic [DATA_WIDTH-1:0] r0_wdata,
   output logic                  r0_ack,
   output logic [DATA_WIDTH-1:0] r0_rdata,
   input  logic                  r1_req,
   input  logic                  r1_we,
   input  logic [ADDR_BITS-1:0]  r1_addr,
   input  logic [DATA_WIDTH-1:0] r1_wdata,
   output logic                  r1_ack,
   output logic [DATA_WIDTH-1:0] r1_rdata,
   output logic [ADDR_BITS-1:0]  mem_addr,
   output logic [DATA_WIDTH-1:0] mem_din,
   output logic                  mem_wen,
   input  logic [DATA_WIDTH-1:0] mem_dout
`ifdef ARB_STATS_EN
   ,
   output logic [15:0]           r0_grant_cnt,
   output logic [15:0]           r1_grant_cnt
`endif
);

   typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

   state_t                state_reg, state_next;
   logic                  owner_reg, owner_next;
   logic                  we_reg, we_next;
   logic                  last_grant_reg, last_grant_next;
   logic [ADDR_BITS-1:0]  mem_addr_reg, mem_addr_next;
   logic [DATA_WIDTH-1:0] mem_din_reg, mem_din_next;
   logic                  mem_wen_reg, mem_wen_next;
   logic                  r0_ack_reg, r0_ack_next;
   logic                  r1_ack_reg, r1_ack_next;
   logic [DATA_WIDTH-1:0] r0_rdata_reg, r0_rdata_next;
   logic [DATA_WIDTH-1:0] r1_rdata_reg, r1_rdata_next;
   logic                  grant1;
   logic                  start;

   // Requester 1 wins when it is alone, or when both ask and requester 0
   // was served last (strict alternation under contention).
   assign grant1 = r1_req & (~r0_req | ~last_grant_reg);
   assign start  = (state_reg == IDLE) & (r0_req | r1_req);

   always_comb begin
      state_next      = state_reg;
      owner_next      = owner_reg;
      we_next         = we_reg;
      last_grant_next = last_grant_reg;
      mem_addr_next   = mem_addr_reg;
      mem_din_next    = mem_din_reg;
      mem_wen_next    = 1'b0;
      r0_ack_next     = 1'b0;
      r1_ack_next     = 1'b0;
      r0_rdata_next   = r0_rdata_reg;
      r1_rdata_next   = r1_rdata_reg;
      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next      = ACCESS;
               owner_next      = grant1;
               last_grant_next = grant1;
               we_next         = grant1 ? r1_we    : r0_we;
               mem_addr_next   = grant1 ? r1_addr  : r0_addr;
               mem_din_next    = grant1 ? r1_wdata : r0_wdata;
               mem_wen_next    = grant1 ? r1_we    : r0_we;
            end
         end
         ACCESS: begin
            // The write commits in reg_mem on this edge; a read captures
            // the combinational memory output.
            state_next = ACK;
            if (owner_reg) begin
               r1_ack_next = 1'b1;
               if (!we_reg) r1_rdata_next = mem_dout;
            end else begin
               r0_ack_next = 1'b1;
               if (!we_reg) r0_rdata_next = mem_dout;
            end
         end
         ACK: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= IDLE;
         owner_reg      <= 1'b0;
         we_reg         <= 1'b0;
         last_grant_reg <= 1'b1;
         mem_addr_reg   <= '0;
         mem_din_reg    <= '0;
         mem_wen_reg    <= 1'b0;
         r0_ack_reg     <= 1'b0;
         r1_ack_reg     <= 1'b0;
         r0_rdata_reg   <= '0;
         r1_rdata_reg   <= '0;
      end else begin
         state_reg      <= state_next;
         owner_reg      <= owner_next;
         we_reg         <= we_next;
         last_grant_reg <= last_grant_next;
         mem_addr_reg   <= mem_addr_next;
         mem_din_reg    <= mem_din_next;
         mem_wen_reg    <= mem_wen_next;
         r0_ack_reg     <= r0_ack_next;
         r1_ack_reg     <= r1_ack_next;
         r0_rdata_reg   <= r0_rdata_next;
         r1_rdata_reg   <= r1_rdata_next;
      end
   end

   assign mem_addr = mem_addr_reg;
   assign mem_din  = mem_din_reg;
   assign mem_wen  = mem_wen_reg;
   assign r0_ack   = r0_ack_reg;
   assign r1_ack   = r1_ack_reg;
   assign r0_rdata = r0_rdata_reg;
   assign r1_rdata = r1_rdata_reg;

`ifdef ARB_STATS_EN
   logic [15:0] r0_cnt_reg, r0_cnt_next;
   logic [15:0] r1_cnt_reg, r1_cnt_next;

   always_comb begin
      r0_cnt_next = r0_cnt_reg;
      r1_cnt_next = r1_cnt_reg;
      if (start) begin
         if (grant1) begin
            if (r1_cnt_reg != 16'hFFFF) r1_cnt_next = r1_cnt_reg + 16'd1;
         end else begin
            if (r0_cnt_reg != 16'hFFFF) r0_cnt_next = r0_cnt_reg + 16'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r0_cnt_reg <= '0;
         r1_cnt_reg <= '0;
      end else begin
         r0_cnt_reg <= r0_cnt_next;
         r1_cnt_reg <= r1_cnt_next;
      end
   end

   assign r0_grant_cnt = r0_cnt_reg;
   assign r1_grant_cnt = r1_cnt_reg;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter with a behavioural reg_mem model
//   (combinational read, write on the rising edge while mem_wen is high).
module tb_mem_port_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       r0_req, r0_we, r1_req, r1_we;
   logic [4:0] r0_addr, r1_addr;
   logic [7:0] r0_wdata, r1_wdata;
   logic       r0_ack, r1_ack;
   logic [7:0] r0_rdata, r1_rdata;
   logic [4:0] mem_addr;
   logic [7:0] mem_din;
   logic       mem_wen;
   logic [7:0] mem_dout;
`ifdef ARB_STATS_EN
   logic [15:0] r0_grant_cnt, r1_grant_cnt;
`endif

   logic [7:0] mem [32];
   int checks = 0;
   int errors = 0;
   int n0, n1, last0, last1, exp_owner;
   logic wen_seen;

   always #5 clk = ~clk;

   always @(posedge clk) if (mem_wen) mem[mem_addr] <= mem_din;
   assign mem_dout = mem[mem_addr];

   mem_port_arbiter #(.DATA_WIDTH(8), .ADDR_BITS(5)) dut (
      .clk(clk), .rst(rst),
      .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
      .r0_ack(r0_ack), .r0_rdata(r0_rdata),
      .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
      .r1_ack(r1_ack), .r1_rdata(r1_rdata),
      .mem_addr(mem_addr), .mem_din(mem_din), .mem_wen(mem_wen),
      .mem_dout(mem_dout)
`ifdef ARB_STATS_EN
      , .r0_grant_cnt(r0_grant_cnt), .r1_grant_cnt(r1_grant_cnt)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One uncontended transaction from requester 'who', checked cycle by cycle.
   task automatic run_txn(input bit who, input logic we, input logic [4:0] addr,
                          input logic [7:0] wdata, input logic [7:0] exp, input string tag);
      if (!who) begin
         r0_req = 1'b1; r0_we = we; r0_addr = addr; r0_wdata = wdata;
      end else begin
         r1_req = 1'b1; r1_we = we; r1_addr = addr; r1_wdata = wdata;
      end
      tick();
      check({tag, "_addr"}, 32'(mem_addr), 32'(addr));
      check({tag, "_wen"}, 32'(mem_wen), 32'(we));
      check({tag, "_early_ack"}, 32'(r0_ack | r1_ack), 0);
      if (we) check({tag, "_din"}, 32'(mem_din), 32'(wdata));
      tick();
      check({tag, "_ack"}, 32'(who ? r1_ack : r0_ack), 1);
      check({tag, "_other_ack"}, 32'(who ? r0_ack : r1_ack), 0);
      check({tag, "_wen_off"}, 32'(mem_wen), 0);
      if (!we) check({tag, "_rdata"}, 32'(who ? r1_rdata : r0_rdata), 32'(exp));
      $display("txn %s r%0d we=%0d addr=%0d rdata0=%h rdata1=%h",
               tag, who, we, addr, r0_rdata, r1_rdata);
      if (!who) r0_req = 1'b0; else r1_req = 1'b0;
      tick();
      check({tag, "_ack_end"}, 32'(r0_ack | r1_ack), 0);
   endtask

   initial begin
      for (int i = 0; i < 32; i++) mem[i] = 8'h00;
      rst = 1'b1;
      r0_req = 0; r0_we = 0; r0_addr = 0; r0_wdata = 0;
      r1_req = 0; r1_we = 0; r1_addr = 0; r1_wdata = 0;
      tick(); tick();
      check("rst_wen", 32'(mem_wen), 0);
      check("rst_addr", 32'(mem_addr), 0);
      check("rst_din", 32'(mem_din), 0);
      check("rst_acks", 32'({r0_ack, r1_ack}), 0);
      check("rst_rdata", 32'({r0_rdata, r1_rdata}), 0);
      rst = 1'b0;
      tick();

      // Write then read, single requester.
      run_txn(1'b0, 1'b1, 5'd5, 8'h2A, 8'h00, "wr5");
      run_txn(1'b0, 1'b0, 5'd5, 8'h00, 8'h2A, "rd5");
      check("rd5_r1_untouched", 32'(r1_rdata), 0);

      // Contention directly after reset: r0 first, r1 three cycles later.
      rst = 1'b1; #1; rst = 1'b0;
      tick();
      r0_req = 1; r0_we = 1; r0_addr = 5'd3; r0_wdata = 8'h11;
      r1_req = 1; r1_we = 1; r1_addr = 5'd4; r1_wdata = 8'h22;
      tick();
      check("cont_addr0", 32'(mem_addr), 3);
      check("cont_din0", 32'(mem_din), 32'h11);
      tick();
      check("cont_ack0", 32'({r0_ack, r1_ack}), 32'b10);
      r0_req = 0;
      tick();
      tick();
      check("cont_addr1", 32'(mem_addr), 4);
      check("cont_din1", 32'(mem_din), 32'h22);
      tick();
      check("cont_ack1", 32'({r0_ack, r1_ack}), 32'b01);
      r1_req = 0;
      tick();
      run_txn(1'b0, 1'b0, 5'd3, 8'h00, 8'h11, "rd3");
      run_txn(1'b1, 1'b0, 5'd4, 8'h00, 8'h22, "rd4");

      // Fairness: both hold read requests; last grant was r1, so r0 leads.
      r0_req = 1; r0_we = 0; r0_addr = 5'd3;
      r1_req = 1; r1_we = 0; r1_addr = 5'd4;
      n0 = 0; n1 = 0; last0 = 0; last1 = 0; exp_owner = 0; wen_seen = 1'b0;
      for (int c = 1; c <= 36; c++) begin
         tick();
         if (mem_wen) wen_seen = 1'b1;
         if (r0_ack | r1_ack) begin
            check("fair_both", 32'(r0_ack & r1_ack), 0);
            check("fair_owner", 32'(r1_ack), 32'(exp_owner));
            if (r0_ack) begin
               check("fair_rdata0", 32'(r0_rdata), 32'h11);
               if (n0 > 0) check("fair_gap0", 32'(c - last0), 6);
               last0 = c; n0++;
            end else begin
               check("fair_rdata1", 32'(r1_rdata), 32'h22);
               if (n1 > 0) check("fair_gap1", 32'(c - last1), 6);
               last1 = c; n1++;
            end
            $display("fair ack cycle=%0d owner=r%0d", c, r1_ack);
            exp_owner ^= 1;
         end
      end
      r0_req = 0; r1_req = 0;
      check("fair_n0", 32'(n0), 6);
      check("fair_n1", 32'(n1), 6);
      check("fair_first_wait", 32'(last0 < last1), 1);
      check("fair_no_wen", 32'(wen_seen), 0);
      tick();

      // Same-address hazard: r0 wins (last grant r1), r1 reads the new data.
      r0_req = 1; r0_we = 1; r0_addr = 5'd31; r0_wdata = 8'hA5;
      r1_req = 1; r1_we = 0; r1_addr = 5'd31;
      tick();
      check("haz_wen", 32'(mem_wen), 1);
      tick();
      check("haz_ack0", 32'({r0_ack, r1_ack}), 32'b10);
      check("haz_r1_hold_a", 32'(r1_rdata), 32'h22);
      r0_req = 0;
      tick();
      tick();
      check("haz_r1_hold_b", 32'(r1_rdata), 32'h22);
      tick();
      check("haz_ack1", 32'({r0_ack, r1_ack}), 32'b01);
      check("haz_rdata", 32'(r1_rdata), 32'hA5);
      r1_req = 0;
      tick();

      // Reset during ACCESS of an r1 write; old data must survive.
      run_txn(1'b0, 1'b1, 5'd7, 8'h10, 8'h00, "wr7");
      r1_req = 1; r1_we = 1; r1_addr = 5'd7; r1_wdata = 8'hFF;
      tick();
      check("rmid_wen_before", 32'(mem_wen), 1);
      rst = 1'b1;
      #1;
      check("rmid_wen_drop", 32'(mem_wen), 0);
      @(posedge clk); #1;
      check("rmid_no_ack", 32'(r1_ack), 0);
      rst = 1'b0; r1_req = 0;
      tick();
      check("rmid_no_ack_late", 32'(r1_ack), 0);
      r0_req = 1; r0_we = 0; r0_addr = 5'd7;
      r1_req = 1; r1_we = 0; r1_addr = 5'd5;
      tick();
      tick();
      check("rmid_first", 32'({r0_ack, r1_ack}), 32'b10);
      check("rmid_rd7", 32'(r0_rdata), 32'h10);
      r0_req = 0;
      tick(); tick(); tick();
      check("rmid_second", 32'({r0_ack, r1_ack}), 32'b01);
      check("rmid_rd5", 32'(r1_rdata), 32'h2A);
      r1_req = 0;
      tick();

`ifdef ARB_STATS_EN
      rst = 1'b1; #1; rst = 1'b0;
      tick();
      for (int i = 0; i < 5; i++) run_txn(1'b0, 1'b0, 5'd3, 8'h00, 8'h11, "st0");
      for (int i = 0; i < 3; i++) run_txn(1'b1, 1'b0, 5'd4, 8'h00, 8'h22, "st1");
      check("stats_r0", 32'(r0_grant_cnt), 5);
      check("stats_r1", 32'(r1_grant_cnt), 3);
      rst = 1'b1; #1;
      check("stats_rst", 32'({r0_grant_cnt, r1_grant_cnt}), 0);
      rst = 1'b0;
      tick();
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
